control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 156 +++++++++++++++
 tb/tb_control_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch (T0-T2) and per-opcode execute (T3-T7)
// cycles and decodes the datapath strobes from the current state and IR.
module control_sequencer (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  opcode,
    output logic        Run,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t state_q, state_d;

    logic [4:0]  op;
    logic        is_rtype, is_imm, is_mem, is_ld;
    logic [15:0] ra_hot, rb_hot, rc_hot;
    state_t      eoi_next;

    assign op       = IR[31:27];
    assign is_rtype = (op >= 5'b00011) && (op <= 5'b00110);
    assign is_imm   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    assign is_ld    = (op == OP_LD);
    assign is_mem   = is_ld || (op == OP_ST);
    assign ra_hot   = 16'd1 << IR[26:23];
    assign rb_hot   = 16'd1 << IR[22:19];
    assign rc_hot   = 16'd1 << IR[18:15];
    // Stop only matters on the cycle that completes an instruction.
    assign eoi_next = Stop ? S_HALT : S_T0;
    assign state_o  = state_q;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Rin     = '0;
        Rout    = '0;
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        opcode  = 5'b00000;
        Run     = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_rtype || is_imm || is_mem) begin
                    Rout    = rb_hot;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = eoi_next;
                end
            end
            S_T4: begin
                Zin     = 1'b1;
                state_d = S_T5;
                if (is_rtype) begin
                    Rout   = rc_hot;
                    opcode = op;
                end else begin
                    // Immediates map onto their register-form ALU ops; ld/st add.
                    Cout = 1'b1;
                    case (op)
                        OP_ANDI: opcode = OP_AND;
                        OP_ORI:  opcode = OP_OR;
                        default: opcode = OP_ADD;
                    endcase
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_mem) begin
                    MARin   = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = ra_hot;
                    state_d = eoi_next;
                end
            end
            S_T6: begin
                MDRin   = 1'b1;
                state_d = S_T7;
                if (is_ld) Read = 1'b1;
                else       Rout = ra_hot;
            end
            S_T7: begin
                state_d = eoi_next;
                if (is_ld) begin
                    MDRout = 1'b1;
                    Rin    = ra_hot;
                end else begin
                    Write = 1'b1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instructions plus a randomized
// instruction stream checked cycle by cycle against a microstep model.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        Stop;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Cout, Read, Write, Run;
    logic [4:0]  opcode;
    logic [3:0]  state_o;

    typedef struct packed {
        logic        run;
        logic [15:0] rin;
        logic [15:0] rout;
        logic        pcout, pcin, incpc, marin, mdrin, mdrout, irin;
        logic        yin, zin, zlowout, cout, read, write;
        logic [4:0]  opcode;
    } ctl_t;

    int checks = 0;
    int errors = 0;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Cout(Cout), .Read(Read), .Write(Write),
        .opcode(opcode), .Run(Run), .state_o(state_o)
    );

    // clock/reset block
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [50:0] act, input logic [50:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o.run = Run; o.rin = Rin; o.rout = Rout;
        o.pcout = PCout; o.pcin = PCin; o.incpc = IncPC; o.marin = MARin;
        o.mdrin = MDRin; o.mdrout = MDRout; o.irin = IRin; o.yin = Yin;
        o.zin = Zin; o.zlowout = Zlowout; o.cout = Cout; o.read = Read;
        o.write = Write; o.opcode = opcode;
        return o;
    endfunction

    // reference model: instruction class and per-microstep control word
    function automatic int op_class(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd6)   return 1; // register ALU
        if (op >= 5'd12 && op <= 5'd14) return 2; // immediate ALU
        if (op == 5'd0)                 return 3; // ld
        if (op == 5'd2)                 return 4; // st
        if (op == 5'd27)                return 5; // halt
        return 0;
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        int k;
        k = op_class(op);
        if (k == 1 || k == 2) return 6;
        if (k == 3 || k == 4) return 8;
        return 4;
    endfunction

    function automatic ctl_t expect_ctl(input logic [31:0] ir, input int step);
        ctl_t e;
        int   k;
        int   ra, rb, rc;
        e = '0;
        e.run = 1'b1;
        k  = op_class(ir[31:27]);
        ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        case (step)
            0: begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1; end
            1: begin e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; end
            2: begin e.mdrout = 1; e.irin = 1; end
            3: if (k >= 1 && k <= 4) begin e.rout[rb] = 1'b1; e.yin = 1; end
            4: begin
                e.zin = 1;
                if (k == 1) begin
                    e.rout[rc] = 1'b1;
                    e.opcode = ir[31:27];
                end else begin
                    e.cout = 1;
                    e.opcode = (ir[31:27] == 5'd13) ? 5'd5 : (ir[31:27] == 5'd14) ? 5'd6 : 5'd3;
                end
            end
            5: begin
                e.zlowout = 1;
                if (k >= 3) e.marin = 1;
                else        e.rin[ra] = 1'b1;
            end
            6: begin
                e.mdrin = 1;
                if (k == 3) e.read = 1;
                else        e.rout[ra] = 1'b1;
            end
            7: if (k == 3) begin e.mdrout = 1; e.rin[ra] = 1'b1; end
               else          e.write = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    // driver: one instruction; Stop high only during step stop_step,
    // clear pulled low right after step abort_step is checked
    task automatic run_instr(input logic [31:0] ir, input int stop_step,
                             input int abort_step, output bit halted);
        int   n;
        ctl_t exp_q[$];
        n = instr_len(ir[31:27]);
        halted = 1'b0;
        for (int s = 0; s < n; s++) exp_q.push_back(expect_ctl(ir, s));
        for (int s = 0; s < n; s++) begin
            @(posedge Clock); #1;
            Stop = (s == stop_step);
            check_val($sformatf("op%0d_step%0d", ir[31:27], s), observed(), exp_q.pop_front());
            if (s == 2) IR = ir;
            if (s == abort_step) begin
                #2 clear = 1'b0;
                #1 check_val("abort_async", observed(), '0);
                @(posedge Clock); #1;
                check_val("abort_held", observed(), '0);
                @(negedge Clock);
                clear = 1'b1;
                Stop  = 1'b0;
                return;
            end
        end
        halted = (op_class(ir[31:27]) == 5) || (stop_step == n - 1);
    endtask

    task automatic check_halt(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clock); #1;
            Stop = 1'($urandom_range(0, 1));
            check_val($sformatf("halt_c%0d", i), observed(), '0);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        clear = 1'b0;
        #1 check_val("reset_async", observed(), '0);
        @(posedge Clock); #1;
        check_val("reset_held", observed(), '0);
        @(negedge Clock);
        clear = 1'b1;
        Stop  = 1'b0;
    endtask

    initial begin
        bit          h;
        logic [4:0]  op;
        logic [31:0] ir;
        logic [4:0]  op_tab [10];
        int          stp, abt;
        op_tab = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd27};

        clear = 1'b1; Stop = 1'b0; IR = '0;
        #2 clear = 1'b0;
        #1 check_val("reset_init", observed(), '0);
        repeat (2) @(posedge Clock);
        #1 check_val("reset_clocked", observed(), '0);
        @(negedge Clock);
        clear = 1'b1;

        run_instr(32'h1891_8000, -1, -1, h);                              // add R1,R2,R3
        run_instr(mk_ir(5'd12, 4'd4, 4'd5, 19'h7FFFD), -1, -1, h);        // addi R4,R5,-3
        run_instr(mk_ir(5'd0, 4'd6, 4'd7, 19'd16), -1, -1, h);            // ld R6,16(R7)
        run_instr(mk_ir(5'd2, 4'd6, 4'd7, 19'd16), -1, -1, h);            // st R6,16(R7)
        run_instr(mk_ir(5'd31, 4'd9, 4'd1, 19'h12345), -1, -1, h);        // undefined op
        run_instr(mk_ir(5'd14, 4'd15, 4'd0, 19'h00FF0), -1, -1, h);       // ori
        run_instr(32'h1891_8000, 3, -1, h);                               // Stop at T3 ignored
        run_instr(32'h1891_8000, -1, 4, h);                               // clear during T4
        run_instr(32'h1891_8000, 5, -1, h);                               // Stop at T5 halts
        check_val("stop_halted", 51'(h), 51'(1));
        check_halt(12);
        do_reset();
        run_instr(mk_ir(5'd27, 4'd0, 4'd0, 19'd0), -1, -1, h);            // halt
        check_halt(12);
        do_reset();

        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                             : op_tab[$urandom_range(0, 9)];
            ir  = mk_ir(op, 4'($urandom), 4'($urandom), 19'($urandom));
            stp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
            abt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(ir, stp, abt, h);
            if (h) begin
                check_halt(int'($urandom_range(2, 12)));
                do_reset();
            end
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
